// File: rtl/s298_bist_ctrl.sv
// BIST wrapper for s298: LFSR drives G0..G2, MISR compacts the 6 registered outputs, compares to GOLDEN.
// Latency: done rises INIT_CYCLES+N_PATTERNS+2 edges after the edge that samples start.
// Backpressure: none; start is honoured only in IDLE/DONE and is ignored on the first edge after reset release.
module s298_bist_ctrl #(
    parameter int          N_PATTERNS  = 255,
    parameter int          INIT_CYCLES = 2,
    parameter int          CNT_W       = 16,
    parameter logic [7:0]  LFSR_POLY   = 8'hB8,
    parameter logic [7:0]  LFSR_SEED   = 8'h01,
    parameter logic [7:0]  MISR_POLY   = 8'hB8,
    parameter logic [7:0]  GOLDEN      = 8'h00
) (
    input  logic       CK,
    input  logic       RN,
    input  logic       start,
    output logic       tpg_g0,
    output logic       tpg_g1,
    output logic       tpg_g2,
    input  logic [5:0] cut_resp,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] signature
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_FLUSH,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(N_PATTERNS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       lfsr;
    logic [7:0]       misr;
    logic [7:0]       misr_nxt;
    logic             armed;
    logic             go;

    // armed stays low for the first edge after reset so a start overlapping RN release is dropped
    assign go        = start && armed;
    assign signature = misr;
    assign misr_nxt  = {misr[6:0], 1'b0} ^ (misr[7] ? MISR_POLY : 8'h00) ^ {2'b00, cut_resp};

    // State register
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and CUT-facing outputs; G0 holds the CUT cleared whenever no run is in progress
    always_comb begin
        state_nxt = state;
        tpg_g0    = 1'b0;
        tpg_g1    = 1'b0;
        tpg_g2    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                tpg_g0 = 1'b1;
                if (go) state_nxt = S_INIT;
            end
            S_INIT: begin
                tpg_g0 = 1'b1;
                busy   = 1'b1;
                if (cnt == INIT_LAST) state_nxt = S_RUN;
            end
            S_RUN: begin
                tpg_g1 = lfsr[0];
                tpg_g2 = lfsr[1];
                busy   = 1'b1;
                if (cnt == RUN_LAST) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                busy      = 1'b1;
                state_nxt = S_CHECK;
            end
            S_CHECK: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                tpg_g0 = 1'b1;
                done   = 1'b1;
                if (go) state_nxt = S_INIT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: counter, TPG LFSR, MISR and the registered pass flag.
    // The CUT response lags its pattern by one cycle, so the first RUN cycle is skipped
    // and FLUSH supplies the last capture.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            cnt   <= '0;
            lfsr  <= LFSR_SEED;
            misr  <= 8'h00;
            pass  <= 1'b0;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        cnt  <= '0;
                        lfsr <= LFSR_SEED;
                        misr <= 8'h00;
                        pass <= 1'b0;
                    end
                end
                S_INIT: begin
                    lfsr <= LFSR_SEED;
                    misr <= 8'h00;
                    cnt  <= (cnt == INIT_LAST) ? '0 : cnt + 1'b1;
                end
                S_RUN: begin
                    lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_POLY) : (lfsr >> 1);
                    if (cnt != '0) misr <= misr_nxt;
                    cnt  <= (cnt == RUN_LAST) ? '0 : cnt + 1'b1;
                end
                S_FLUSH: begin
                    misr <= misr_nxt;
                end
                S_CHECK: begin
                    pass <= (misr == GOLDEN);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_s298_bist_ctrl.sv
// Bench for s298_bist_ctrl: random CUT responses against a cycle-indexed reference of the BIST run.
// Instance a: N=8, INIT=2, GOLDEN=0. Instance b: N=1, INIT=1, GOLDEN=1 fed a constant 6'h01.
// Inputs driven and outputs sampled on the falling edge.
module tb_s298_bist_ctrl;

    localparam int         N_A      = 8;
    localparam int         INIT_A   = 2;
    localparam logic [7:0] GOLDEN_A = 8'h00;
    localparam logic [7:0] POLY     = 8'hB8;

    logic       CK;
    logic       RN;
    logic       start;
    logic [5:0] cut_resp;
    logic       tpg_g0, tpg_g1, tpg_g2, busy, done, pass;
    logic [7:0] signature;
    logic       b_g0, b_g1, b_g2, b_busy, b_done, b_pass;
    logic [7:0] b_sig;
    logic [5:0] b_resp;

    int checks;
    int failures;

    // Expected pattern sequence for seed 01, mask B8
    logic [7:0] lfsr_tab [8];

    s298_bist_ctrl #(
        .N_PATTERNS(N_A), .INIT_CYCLES(INIT_A), .CNT_W(16),
        .LFSR_POLY(POLY), .LFSR_SEED(8'h01), .MISR_POLY(POLY), .GOLDEN(GOLDEN_A)
    ) u_dut (
        .CK(CK), .RN(RN), .start(start),
        .tpg_g0(tpg_g0), .tpg_g1(tpg_g1), .tpg_g2(tpg_g2),
        .cut_resp(cut_resp),
        .busy(busy), .done(done), .pass(pass), .signature(signature)
    );

    s298_bist_ctrl #(
        .N_PATTERNS(1), .INIT_CYCLES(1), .CNT_W(16),
        .LFSR_POLY(POLY), .LFSR_SEED(8'h01), .MISR_POLY(POLY), .GOLDEN(8'h01)
    ) u_dut_n1 (
        .CK(CK), .RN(RN), .start(start),
        .tpg_g0(b_g0), .tpg_g1(b_g1), .tpg_g2(b_g2),
        .cut_resp(b_resp),
        .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] misr_ref(input logic [7:0] s, input logic [5:0] r);
        int v;
        v = (int'(s) * 2) % 256;
        if (s >= 8'h80) v = v ^ int'(POLY);
        v = v ^ int'(r);
        return 8'(v);
    endfunction

    // One run of instance a, indexed by t = edges since the edge that samples start.
    // mode 0: random responses, 1: all-zero responses, 2: start pulse during RUN, 3: RN drop mid-RUN
    task automatic run_one(input int mode);
        logic [7:0] sig_m;
        int         last;
        logic       exp_g1, exp_g2;
        last  = INIT_A + N_A + 2;
        sig_m = 8'h00;
        @(negedge CK);
        start    = 1'b1;
        cut_resp = 6'h00;
        @(negedge CK);
        start = 1'b0;
        for (int t = 0; t <= last; t++) begin
            check("busy", busy, (t < last));
            check("done", done, (t == last));
            check("tpg_g0", tpg_g0, (t < INIT_A) || (t == last));
            exp_g1 = 1'b0;
            exp_g2 = 1'b0;
            if (t >= INIT_A && t < INIT_A + N_A) begin
                exp_g1 = lfsr_tab[t - INIT_A][0];
                exp_g2 = lfsr_tab[t - INIT_A][1];
            end
            check("tpg_g1", tpg_g1, exp_g1);
            check("tpg_g2", tpg_g2, exp_g2);
            check("signature", signature, sig_m);
            check("pass", pass, (t == last) && (sig_m == GOLDEN_A));
            if (t == 4) begin
                check("n1_done", b_done, 1'b1);
                check("n1_signature", b_sig, 8'h01);
                check("n1_pass", b_pass, 1'b1);
            end
            if (mode == 3 && t == INIT_A + 3) begin
                RN = 1'b0;
                #1;
                check("abort_busy", busy, 1'b0);
                check("abort_g0", tpg_g0, 1'b1);
                check("abort_signature", signature, 8'h00);
                check("abort_done", done, 1'b0);
                return;
            end
            if (t == last) break;
            start    = (mode == 2) && (t == INIT_A + 1);
            cut_resp = (mode == 1) ? 6'h00 : 6'($urandom_range(0, 63));
            if (t + 1 >= INIT_A + 2 && t + 1 <= INIT_A + N_A + 1)
                sig_m = misr_ref(sig_m, cut_resp);
            @(negedge CK);
        end
        start = 1'b0;
    endtask

    // Release reset with start already high; the first edge must not launch a run
    task automatic release_with_start();
        @(negedge CK);
        RN    = 1'b1;
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        check("start_at_release_busy", busy, 1'b0);
        check("start_at_release_n1_busy", b_busy, 1'b0);
        check("idle_g0", tpg_g0, 1'b1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        lfsr_tab[0] = 8'h01; lfsr_tab[1] = 8'hB8; lfsr_tab[2] = 8'h5C; lfsr_tab[3] = 8'h2E;
        lfsr_tab[4] = 8'h17; lfsr_tab[5] = 8'hB3; lfsr_tab[6] = 8'hE1; lfsr_tab[7] = 8'hC8;
        RN       = 1'b0;
        start    = 1'b0;
        cut_resp = 6'h00;
        b_resp   = 6'h01;
        #12;
        check("rst_g0", tpg_g0, 1'b1);
        check("rst_g1", tpg_g1, 1'b0);
        check("rst_g2", tpg_g2, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_signature", signature, 8'h00);

        release_with_start();
        run_one(1);
        for (int i = 0; i < 3; i++) run_one(0);
        run_one(2);
        run_one(3);
        release_with_start();
        run_one(0);
        run_one(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
